// File: rtl/imem_rsp.sv
// ============================================================================
// Module   : imem_rsp
// Purpose  : Instruction-memory responder for the fetch interface. Accepts one
//            request at a time, waits WAIT_STATES cycles and then returns the
//            addressed word (or NOP_WORD with an error flag) under a
//            valid/ready handshake. A side load port preloads the RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_rsp #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH_in,
  input  logic        REQ_valid_in,
  input  logic [31:0] REQ_addr_in,
  output logic        REQ_ready_out,
  output logic        RSP_valid_out,
  input  logic        RSP_ready_in,
  output logic [31:0] RSP_instr_out,
  output logic [31:0] RSP_addr_out,
  output logic        RSP_err_out,
  input  logic        LD_we_in,
  input  logic [31:0] LD_addr_in,
  input  logic [31:0] LD_data_in
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam logic [31:0] c_DEPTH     = 32'(DEPTH_WORDS);
  localparam logic        c_HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0]  c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_rst_d;
  logic [3:0]  r_cnt;
  logic [31:0] r_req_addr;
  logic        r_req_err;
  logic [31:0] r_rsp_instr;
  logic [31:0] r_rsp_addr;
  logic        r_rsp_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_req_ready;
  logic          w_accept;
  logic          w_capture;
  logic          w_in_err;
  logic          w_ld_ok;
  logic [AW-1:0] w_ld_idx;
  logic [31:0]   w_rd_addr;
  logic          w_rd_err;
  logic [AW-1:0] w_rd_idx;
  logic [31:0]   w_rd_word;
  logic          w_unused;

  // Ready is held low for the cycle following a reset edge, then tracks IDLE.
  assign w_req_ready = (r_state == S_IDLE) && !r_rst_d;
  assign w_accept    = w_req_ready && REQ_valid_in && !FLUSH_in;
  assign w_in_err    = (REQ_addr_in[1:0] != 2'b00) ||
                       ({2'b00, REQ_addr_in[31:2]} >= c_DEPTH);

  assign w_ld_ok  = LD_we_in && ({2'b00, LD_addr_in[31:2]} < c_DEPTH);
  assign w_ld_idx = LD_addr_in[AW+1:2];
  assign w_unused = ^LD_addr_in[1:0];

  // With no wait states the capture happens on the accept edge, so the read
  // must come straight from the request bus instead of the latched address.
  assign w_rd_addr = (r_state == S_IDLE) ? REQ_addr_in : r_req_addr;
  assign w_rd_err  = (r_state == S_IDLE) ? w_in_err    : r_req_err;
  assign w_rd_idx  = w_rd_addr[AW+1:2];
  // Write-first bypass: a load to the word being captured wins.
  assign w_rd_word = (w_ld_ok && (w_ld_idx == w_rd_idx)) ? LD_data_in : r_mem[w_rd_idx];

  assign REQ_ready_out = w_req_ready;
  assign RSP_valid_out = (r_state == S_RESP);
  assign RSP_instr_out = r_rsp_instr;
  assign RSP_addr_out  = r_rsp_addr;
  assign RSP_err_out   = r_rsp_err;

  // Next-state decode; flush in WAIT/RESP always returns to IDLE.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (c_HAS_WAIT) begin
            w_next = S_WAIT;
          end else begin
            w_next    = S_RESP;
            w_capture = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (FLUSH_in) begin
          w_next = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_next    = S_RESP;
          w_capture = 1'b1;
        end
      end
      S_RESP: begin
        if (FLUSH_in || RSP_ready_in) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register and reset-cycle marker.
  always_ff @(posedge CLK) begin
    r_rst_d <= RST;
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request latch and wait-state counter (only decremented while nonzero).
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt      <= 4'd0;
      r_req_addr <= 32'd0;
      r_req_err  <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= c_WAIT_LOAD;
      r_req_addr <= REQ_addr_in;
      r_req_err  <= w_in_err;
    end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Response registers, loaded on the edge that enters RESP.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rsp_instr <= 32'd0;
      r_rsp_addr  <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else if (w_capture) begin
      r_rsp_instr <= w_rd_err ? NOP_WORD : w_rd_word;
      r_rsp_addr  <= w_rd_addr;
      r_rsp_err   <= w_rd_err;
    end
  end

  // Instruction RAM load port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (w_ld_ok) begin
      r_mem[w_ld_idx] <= LD_data_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_rsp.sv
// ============================================================================
// Module   : tb_imem_rsp
// Purpose  : Directed self-checking bench for imem_rsp with a response
//            scoreboard. Instance A uses one wait state, instance B none.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_rsp;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_flush = 0, a_req_valid = 0, a_rsp_ready = 1, a_ld_we = 0;
  logic [31:0] a_req_addr = 0, a_ld_addr = 0, a_ld_data = 0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_instr, a_rsp_addr;

  logic        b_flush = 0, b_req_valid = 0, b_rsp_ready = 1, b_ld_we = 0;
  logic [31:0] b_req_addr = 0, b_ld_addr = 0, b_ld_data = 0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_instr, b_rsp_addr;

  imem_rsp #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1), .NOP_WORD(NOP)) u_dut_a (
    .CLK(clk), .RST(rst), .FLUSH_in(a_flush),
    .REQ_valid_in(a_req_valid), .REQ_addr_in(a_req_addr), .REQ_ready_out(a_req_ready),
    .RSP_valid_out(a_rsp_valid), .RSP_ready_in(a_rsp_ready),
    .RSP_instr_out(a_rsp_instr), .RSP_addr_out(a_rsp_addr), .RSP_err_out(a_rsp_err),
    .LD_we_in(a_ld_we), .LD_addr_in(a_ld_addr), .LD_data_in(a_ld_data)
  );

  imem_rsp #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .NOP_WORD(NOP)) u_dut_b (
    .CLK(clk), .RST(rst), .FLUSH_in(b_flush),
    .REQ_valid_in(b_req_valid), .REQ_addr_in(b_req_addr), .REQ_ready_out(b_req_ready),
    .RSP_valid_out(b_rsp_valid), .RSP_ready_in(b_rsp_ready),
    .RSP_instr_out(b_rsp_instr), .RSP_addr_out(b_rsp_addr), .RSP_err_out(b_rsp_err),
    .LD_we_in(b_ld_we), .LD_addr_in(b_ld_addr), .LD_data_in(b_ld_data)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] mdl_a [int];
  logic [31:0] mdl_b [int];
  int          checks   = 0;
  int          failures = 0;
  int          lat;
  logic [31:0] snap_instr, snap_addr;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic fail_to(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  function automatic rsp_t model(input bit sel_b, input logic [31:0] addr);
    rsp_t r;
    int   idx;
    idx    = int'(addr[31:2]);
    r.addr = addr;
    r.err  = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
    if (r.err)                           r.instr = NOP;
    else if (sel_b && mdl_b.exists(idx)) r.instr = mdl_b[idx];
    else if (!sel_b && mdl_a.exists(idx)) r.instr = mdl_a[idx];
    else                                 r.instr = 'x;
    return r;
  endfunction

  task automatic check_rsp(input string tag, input logic [31:0] instr,
                           input logic [31:0] addr, input logic err);
    rsp_t e;
    if (sb.size() == 0) begin
      fail_to({tag, "_sb_empty"});
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, instr, e.instr);
      chk({tag, "_addr"}, addr, e.addr);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
    end
  endtask

  task automatic load_a(input logic [31:0] addr, input logic [31:0] data);
    a_ld_we = 1; a_ld_addr = addr; a_ld_data = data;
    tick();
    a_ld_we = 0;
    if (addr[31:2] < 30'(DEPTH)) mdl_a[int'(addr[31:2])] = data;
  endtask

  task automatic load_b(input logic [31:0] addr, input logic [31:0] data);
    b_ld_we = 1; b_ld_addr = addr; b_ld_data = data;
    tick();
    b_ld_we = 0;
    if (addr[31:2] < 30'(DEPTH)) mdl_b[int'(addr[31:2])] = data;
  endtask

  // Present a request on A; returns in the first cycle after acceptance.
  task automatic accept_a(input logic [31:0] addr);
    int n = 0;
    a_req_addr = addr; a_req_valid = 1;
    while (!a_req_ready && n < 10) begin tick(); n++; end
    if (!a_req_ready) fail_to("a_accept");
    sb.push_back(model(1'b0, addr));
    tick();
    a_req_valid = 0;
  endtask

  task automatic wait_valid_a(output int l);
    l = 1;
    while (!a_rsp_valid && l < 20) begin tick(); l++; end
    if (!a_rsp_valid) fail_to("a_valid");
  endtask

  // Full transaction on A, optionally stalling the consumer for 'hold' cycles.
  task automatic req_a(input string tag, input logic [31:0] addr, input int hold);
    int l;
    a_rsp_ready = (hold == 0);
    accept_a(addr);
    wait_valid_a(l);
    chk({tag, "_latency"}, 32'(l), 32'd2);
    check_rsp(tag, a_rsp_instr, a_rsp_addr, a_rsp_err);
    if (hold > 0) begin
      snap_instr = a_rsp_instr; snap_addr = a_rsp_addr;
      repeat (hold) begin
        tick();
        chk({tag, "_hold_valid"}, {31'd0, a_rsp_valid}, 32'd1);
        chk({tag, "_hold_instr"}, a_rsp_instr, snap_instr);
        chk({tag, "_hold_addr"}, a_rsp_addr, snap_addr);
        chk({tag, "_hold_reqrdy"}, {31'd0, a_req_ready}, 32'd0);
      end
      a_rsp_ready = 1;
    end
    tick();
    chk({tag, "_valid_drop"}, {31'd0, a_rsp_valid}, 32'd0);
    chk({tag, "_idle_ready"}, {31'd0, a_req_ready}, 32'd1);
  endtask

  initial begin
    // Reset
    rst = 1;
    tick();
    chk("rst_reqrdy", {31'd0, a_req_ready}, 32'd0);
    chk("rst_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rst_instr", a_rsp_instr, 32'd0);
    chk("rst_addr", a_rsp_addr, 32'd0);
    chk("rst_err", {31'd0, a_rsp_err}, 32'd0);
    rst = 0;
    tick();
    chk("post_rst_reqrdy", {31'd0, a_req_ready}, 32'd1);

    // Preload A; the out-of-range write must not alias onto word 0
    load_a(32'h0000_0010, 32'h0050_0093);
    load_a(32'h0000_0014, 32'h1111_1111);
    load_a(32'h0000_0000, 32'hAAAA_0001);
    load_a(32'(4 * DEPTH), 32'hBAD0_BAD0);

    // Basic read, misaligned, out of range
    req_a("rd10", 32'h0000_0010, 0);
    req_a("mis12", 32'h0000_0012, 0);
    req_a("oor", 32'(4 * DEPTH), 0);

    // Consumer stall in RESP
    req_a("hold", 32'h0000_0010, 5);

    // Flush during WAIT
    a_rsp_ready = 1;
    accept_a(32'h0000_0014);
    a_flush = 1;
    chk("flw_valid_wait", {31'd0, a_rsp_valid}, 32'd0);
    tick();
    a_flush = 0;
    sb.delete();
    chk("flw_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("flw_idle", {31'd0, a_req_ready}, 32'd1);
    repeat (3) begin
      tick();
      chk("flw_quiet", {31'd0, a_rsp_valid}, 32'd0);
    end

    // Flush in RESP while the consumer is ready: flush wins
    accept_a(32'h0000_0014);
    wait_valid_a(lat);
    a_flush = 1;
    tick();
    a_flush = 0;
    sb.delete();
    chk("flr_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("flr_idle", {31'd0, a_req_ready}, 32'd1);
    tick();
    chk("flr_quiet", {31'd0, a_rsp_valid}, 32'd0);
    req_a("rd14", 32'h0000_0014, 0);

    // Flush in IDLE blocks acceptance
    a_req_addr = 32'h0000_0010; a_req_valid = 1; a_flush = 1;
    tick();
    a_req_valid = 0; a_flush = 0;
    chk("fli_ready", {31'd0, a_req_ready}, 32'd1);
    tick();
    chk("fli_novalid", {31'd0, a_rsp_valid}, 32'd0);

    // Reset while in WAIT
    accept_a(32'h0000_0010);
    rst = 1;
    tick();
    rst = 0;
    sb.delete();
    chk("rstw_reqrdy", {31'd0, a_req_ready}, 32'd0);
    chk("rstw_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rstw_instr", a_rsp_instr, 32'd0);
    chk("rstw_addr", a_rsp_addr, 32'd0);
    chk("rstw_err", {31'd0, a_rsp_err}, 32'd0);
    tick();
    chk("rstw_reqrdy_after", {31'd0, a_req_ready}, 32'd1);
    chk("rstw_quiet", {31'd0, a_rsp_valid}, 32'd0);
    req_a("ram_keep", 32'h0000_0000, 0);

    // Instance B: zero wait states, back-to-back requests
    load_b(32'h0000_0000, 32'hB000_0001);
    load_b(32'h0000_0004, 32'hB000_0004);
    load_b(32'h0000_0008, 32'h1234_5678);
    b_rsp_ready = 1;
    b_req_valid = 1;
    for (int k = 0; k < 3; k++) begin
      chk("b_accept_ready", {31'd0, b_req_ready}, 32'd1);
      b_req_addr = 32'(k * 4);
      if (k == 2) begin
        b_ld_we = 1; b_ld_addr = 32'h0000_0008; b_ld_data = 32'hDEAD_BEEF;
        mdl_b[2] = 32'hDEAD_BEEF;
      end
      sb.push_back(model(1'b1, b_req_addr));
      tick();
      b_ld_we = 0;
      chk("b_valid", {31'd0, b_rsp_valid}, 32'd1);
      check_rsp("b_rsp", b_rsp_instr, b_rsp_addr, b_rsp_err);
      chk("b_busy_ready", {31'd0, b_req_ready}, 32'd0);
      if (k == 2) b_req_valid = 0;
      tick();
    end
    chk("b_end_valid", {31'd0, b_rsp_valid}, 32'd0);
    chk("b_sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
